regfile_write_arbiter: RTL and testbench

- Owns the single write port of Register_File and shares it between two requesters:
  - the WB stage, which has priority;
  - the multicycle MUL unit, which uses a valid/ready handshake.
- After reset it first runs an init sequence that writes zero to every register.
- Its registered WriteEN/WriteAddr/WriteData outputs connect directly to Register_File.
- An anti-starvation counter guarantees MUL forward progress.

---
 rtl/regfile_write_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// After reset it clears every register, then shares the single write port
// between the WB stage (priority) and the multicycle MUL unit (valid/ready).
// A saturating starvation counter forces a MUL grant after StarveLimit
// consecutive blocked cycles so MUL always makes forward progress.
module regfile_write_arbiter #(
    parameter int unsigned RegWidth    = 16,
    parameter int unsigned AddrBits    = 3,
    parameter int unsigned StarveLimit = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WB_Valid,
    input  logic [AddrBits-1:0] WB_Addr,
    input  logic [RegWidth-1:0] WB_Data,
    output logic                WB_Stall,
    input  logic                MUL_Valid,
    input  logic [AddrBits-1:0] MUL_Addr,
    input  logic [RegWidth-1:0] MUL_Data,
    output logic                MUL_Ready,
    output logic                WriteEN,
    output logic [AddrBits-1:0] WriteAddr,
    output logic [RegWidth-1:0] WriteData,
    output logic                Init_Done
);

    localparam int unsigned StarveW = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);
    localparam logic [AddrBits-1:0] LastAddr = {AddrBits{1'b1}};

    localparam logic StInit = 1'b0;
    localparam logic StRun  = 1'b1;

    logic                state_q, state_d;
    logic [AddrBits-1:0] init_cnt_q, init_cnt_d;
    logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
    logic                write_en_q, write_en_d;
    logic [AddrBits-1:0] write_addr_q, write_addr_d;
    logic [RegWidth-1:0] write_data_q, write_data_d;
    logic                init_done_q, init_done_d;

    logic run;
    logic force_mul;
    logic mul_ready;
    logic wb_stall;
    logic wb_accept;

    // Combinational grant: WB wins unless MUL has been starved long enough.
    always_comb begin
        run       = (state_q == StRun);
        force_mul = run && MUL_Valid && (starve_cnt_q == StarveMax);
        mul_ready = run && MUL_Valid && (!WB_Valid || force_mul);
        // Stall covers INIT too so WB never believes a write landed during the clear.
        wb_stall  = !run || (WB_Valid && force_mul);
        wb_accept = run && WB_Valid && !wb_stall;
    end

    assign MUL_Ready = mul_ready;
    assign WB_Stall  = wb_stall;
    assign WriteEN   = write_en_q;
    assign WriteAddr = write_addr_q;
    assign WriteData = write_data_q;
    assign Init_Done = init_done_q;

    // Next-state: init sweep, registered write issue and starvation tracking.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        starve_cnt_d = starve_cnt_q;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        init_done_d  = init_done_q;

        if (state_q == StInit) begin
            write_en_d   = 1'b1;
            write_addr_d = init_cnt_q;
            write_data_d = '0;
            init_cnt_d   = init_cnt_q + 1'b1;
            if (init_cnt_q == LastAddr) begin
                state_d     = StRun;
                init_done_d = 1'b1;
            end
        end else begin
            if (mul_ready) begin
                write_en_d   = 1'b1;
                write_addr_d = MUL_Addr;
                write_data_d = MUL_Data;
            end else if (wb_accept) begin
                write_en_d   = 1'b1;
                write_addr_d = WB_Addr;
                write_data_d = WB_Data;
            end

            if (MUL_Valid && !mul_ready) begin
                if (starve_cnt_q != StarveMax) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    // State registers; reset drops any write not yet seen by the register file.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StInit;
            init_cnt_q   <= '0;
            starve_cnt_q <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            init_done_q  <= init_done_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: two instances (StarveLimit 3 and 1) share
// the same stimulus; a priority-rule model is checked every falling edge and
// directed steps pin literal expectations.
module tb_regfile_write_arbiter;

    localparam int NumRegs = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WB_Valid;
    logic [2:0]  WB_Addr;
    logic [15:0] WB_Data;
    logic        MUL_Valid;
    logic [2:0]  MUL_Addr;
    logic [15:0] MUL_Data;

    logic        stall_o [2];
    logic        ready_o [2];
    logic        en_o    [2];
    logic [2:0]  addr_o  [2];
    logic [15:0] data_o  [2];
    logic        done_o  [2];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    regfile_write_arbiter #(.RegWidth(16), .AddrBits(3), .StarveLimit(3)) dut (
        .CLK(CLK), .RST(RST),
        .WB_Valid(WB_Valid), .WB_Addr(WB_Addr), .WB_Data(WB_Data), .WB_Stall(stall_o[0]),
        .MUL_Valid(MUL_Valid), .MUL_Addr(MUL_Addr), .MUL_Data(MUL_Data),
        .MUL_Ready(ready_o[0]),
        .WriteEN(en_o[0]), .WriteAddr(addr_o[0]), .WriteData(data_o[0]),
        .Init_Done(done_o[0])
    );

    regfile_write_arbiter #(.RegWidth(16), .AddrBits(3), .StarveLimit(1)) dut1 (
        .CLK(CLK), .RST(RST),
        .WB_Valid(WB_Valid), .WB_Addr(WB_Addr), .WB_Data(WB_Data), .WB_Stall(stall_o[1]),
        .MUL_Valid(MUL_Valid), .MUL_Addr(MUL_Addr), .MUL_Data(MUL_Data),
        .MUL_Ready(ready_o[1]),
        .WriteEN(en_o[1]), .WriteAddr(addr_o[1]), .WriteData(data_o[1]),
        .Init_Done(done_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per instance, remaining clear writes, consecutive MUL losses and the
    // write presented to the register file.
    int          lim       [2] = '{3, 1};
    bit          in_init   [2] = '{1'b1, 1'b1};
    int          next_clr  [2] = '{0, 0};
    int          lost      [2] = '{0, 0};
    bit          m_en      [2] = '{1'b0, 1'b0};
    logic [2:0]  m_addr    [2] = '{3'd0, 3'd0};
    logic [15:0] m_data    [2] = '{16'd0, 16'd0};
    bit          m_done    [2] = '{1'b0, 1'b0};

    function automatic bit mul_wins(input int i);
        if (in_init[i] || !MUL_Valid) return 1'b0;
        return !WB_Valid || (lost[i] >= lim[i]);
    endfunction

    function automatic bit exp_stall(input int i);
        if (in_init[i]) return 1'b1;
        return WB_Valid && mul_wins(i);
    endfunction

    always @(negedge RST) begin
        for (int i = 0; i < 2; i++) begin
            in_init[i]  = 1'b1;
            next_clr[i] = 0;
            lost[i]     = 0;
            m_en[i]     = 1'b0;
            m_addr[i]   = '0;
            m_data[i]   = '0;
            m_done[i]   = 1'b0;
        end
    end

    always @(posedge CLK) begin
        if (RST === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (in_init[i]) begin
                    m_en[i]   = 1'b1;
                    m_addr[i] = 3'(next_clr[i]);
                    m_data[i] = '0;
                    next_clr[i]++;
                    if (next_clr[i] == NumRegs) begin
                        in_init[i] = 1'b0;
                        m_done[i]  = 1'b1;
                    end
                end else begin
                    bit mw;
                    mw = mul_wins(i);
                    if (mw) begin
                        m_en[i] = 1'b1; m_addr[i] = MUL_Addr; m_data[i] = MUL_Data;
                    end else if (WB_Valid) begin
                        m_en[i] = 1'b1; m_addr[i] = WB_Addr; m_data[i] = WB_Data;
                    end else begin
                        m_en[i] = 1'b0;
                    end
                    if (MUL_Valid && !mw) lost[i] = (lost[i] + 1 > lim[i]) ? lim[i] : lost[i] + 1;
                    else lost[i] = 0;
                end
            end
        end
    end

    // Compare process: every falling edge, both instances, all outputs.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d WriteEN", i),   32'(en_o[i]),    32'(m_en[i]));
            check($sformatf("u%0d WriteAddr", i), 32'(addr_o[i]),  32'(m_addr[i]));
            check($sformatf("u%0d WriteData", i), 32'(data_o[i]),  32'(m_data[i]));
            check($sformatf("u%0d Init_Done", i), 32'(done_o[i]),  32'(m_done[i]));
            check($sformatf("u%0d WB_Stall", i),  32'(stall_o[i]), 32'(exp_stall(i)));
            check($sformatf("u%0d MUL_Ready", i), 32'(ready_o[i]), 32'(mul_wins(i)));
        end
    end

    // Register-file image of what instance 1 actually wrote.
    logic [15:0] rf1 [NumRegs];
    always @(posedge CLK) if (en_o[1] === 1'b1) rf1[addr_o[1]] <= data_o[1];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic init_sweep(input string tag);
        for (int k = 0; k < NumRegs; k++) begin
            tick();
            check({tag, " en"},   32'(en_o[0]),   32'd1);
            check({tag, " addr"}, 32'(addr_o[0]), 32'(k));
            check({tag, " data"}, 32'(data_o[0]), 32'd0);
            check({tag, " done"}, 32'(done_o[0]), (k == NumRegs - 1) ? 32'd1 : 32'd0);
            check({tag, " stall"}, 32'(stall_o[0]), 32'd1 & 32'(k != NumRegs - 1));
        end
    endtask

    initial begin
        RST = 1'b0;
        WB_Valid = 1'b0; WB_Addr = '0; WB_Data = '0;
        MUL_Valid = 1'b0; MUL_Addr = '0; MUL_Data = '0;
        #20;
        RST = 1'b1;
        // Requests during INIT must be ignored.
        WB_Valid = 1'b1; WB_Addr = 3'd6; WB_Data = 16'd77;
        MUL_Valid = 1'b1; MUL_Addr = 3'd6; MUL_Data = 16'd88;
        #1;
        check("init stall", 32'(stall_o[0]), 32'd1);
        check("init ready", 32'(ready_o[0]), 32'd0);
        init_sweep("sweep");
        WB_Valid = 1'b0; MUL_Valid = 1'b0;
        tick();
        check("post-init en", 32'(en_o[0]), 32'd0);

        // WB only.
        WB_Valid = 1'b1; WB_Addr = 3'd1; WB_Data = 16'd25;
        #1;
        check("wb stall", 32'(stall_o[0]), 32'd0);
        tick();
        WB_Valid = 1'b0;
        check("wb en", 32'(en_o[0]), 32'd1);
        check("wb addr", 32'(addr_o[0]), 32'd1);
        check("wb data", 32'(data_o[0]), 32'd25);
        tick();
        check("wb idle en", 32'(en_o[0]), 32'd0);
        check("wb hold addr", 32'(addr_o[0]), 32'd1);

        // MUL only.
        MUL_Valid = 1'b1; MUL_Addr = 3'd3; MUL_Data = 16'hFFD8;
        #1;
        check("mul ready", 32'(ready_o[0]), 32'd1);
        tick();
        MUL_Valid = 1'b0;
        check("mul addr", 32'(addr_o[0]), 32'd3);
        check("mul data", 32'(data_o[0]), 32'hFFD8);

        // Conflict: WB wins three times, then MUL is forced through.
        WB_Valid = 1'b1; WB_Addr = 3'd2; WB_Data = 16'd99;
        MUL_Valid = 1'b1; MUL_Addr = 3'd5; MUL_Data = 16'd7;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check($sformatf("conf%0d ready", c), 32'(ready_o[0]), 32'd0);
            check($sformatf("conf%0d stall", c), 32'(stall_o[0]), 32'd0);
            tick();
            check($sformatf("conf%0d addr", c), 32'(addr_o[0]), 32'd2);
            check($sformatf("conf%0d data", c), 32'(data_o[0]), 32'd99);
        end
        #1;
        check("force ready", 32'(ready_o[0]), 32'd1);
        check("force stall", 32'(stall_o[0]), 32'd1);
        tick();
        MUL_Valid = 1'b0;
        check("force addr", 32'(addr_o[0]), 32'd5);
        check("force data", 32'(data_o[0]), 32'd7);
        tick();
        check("resume addr", 32'(addr_o[0]), 32'd2);
        check("resume data", 32'(data_o[0]), 32'd99);
        WB_Valid = 1'b0;
        tick();

        // Same destination on the StarveLimit=1 instance.
        WB_Valid = 1'b1; WB_Addr = 3'd4; WB_Data = 16'd10;
        MUL_Valid = 1'b1; MUL_Addr = 3'd4; MUL_Data = 16'd20;
        #1;
        check("same ready1", 32'(ready_o[1]), 32'd0);
        tick();
        check("same wb addr", 32'(addr_o[1]), 32'd4);
        check("same wb data", 32'(data_o[1]), 32'd10);
        WB_Addr = 3'd6; WB_Data = 16'd11;
        #1;
        check("same ready2", 32'(ready_o[1]), 32'd1);
        check("same stall2", 32'(stall_o[1]), 32'd1);
        tick();
        MUL_Valid = 1'b0;
        check("same mul data", 32'(data_o[1]), 32'd20);
        tick();
        WB_Valid = 1'b0;
        check("r4 final", 32'(rf1[4]), 32'd20);
        tick();

        // Asynchronous reset while a MUL is pending.
        WB_Valid = 1'b1; WB_Addr = 3'd2; WB_Data = 16'd5;
        MUL_Valid = 1'b1; MUL_Addr = 3'd5; MUL_Data = 16'd7;
        tick();
        check("pre-rst en", 32'(en_o[0]), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check("rst en", 32'(en_o[0]), 32'd0);
        check("rst done", 32'(done_o[0]), 32'd0);
        check("rst ready", 32'(ready_o[0]), 32'd0);
        check("rst stall", 32'(stall_o[0]), 32'd1);
        WB_Valid = 1'b0; MUL_Valid = 1'b0;
        #4;
        RST = 1'b1;
        init_sweep("resweep");
        tick();
        check("resweep idle", 32'(en_o[0]), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
